// File: rtl/hamming_pkg.sv
// Shared Hamming(15,11) constants, decode-result type and data-extraction helper.
package hamming_pkg;

  localparam int HAM_CW_W   = 15;
  localparam int HAM_DATA_W = 11;
  localparam int HAM_SYN_W  = 4;

  // Parity bits occupy the power-of-two positions (1-based 1,2,4,8).
  localparam int HAM_P0_IDX = 0;
  localparam int HAM_P1_IDX = 1;
  localparam int HAM_P2_IDX = 3;
  localparam int HAM_P3_IDX = 7;

  // Syndrome bit k covers every codeword index whose 1-based position has bit k set.
  localparam logic [HAM_CW_W-1:0] HAM_SYN_MASK0 = 15'h5555;
  localparam logic [HAM_CW_W-1:0] HAM_SYN_MASK1 = 15'h6666;
  localparam logic [HAM_CW_W-1:0] HAM_SYN_MASK2 = 15'h7878;
  localparam logic [HAM_CW_W-1:0] HAM_SYN_MASK3 = 15'h7F80;

  typedef struct packed {
    logic [HAM_DATA_W-1:0] data;
    logic [HAM_SYN_W-1:0]  synd;
    logic                  corr;
  } ham_dec_t;

  function automatic logic [HAM_DATA_W-1:0] ham_extract(input logic [HAM_CW_W-1:0] cw);
    return {cw[14:HAM_P3_IDX+1], cw[HAM_P3_IDX-1:HAM_P2_IDX+1], cw[HAM_P2_IDX-1]};
  endfunction

endpackage

// File: rtl/hamming15_11_correct.sv
// Combinational Hamming(15,11) single-error corrector: codeword -> {data, syndrome, corrected}.
module hamming15_11_correct
  import hamming_pkg::*;
(
  input  logic [HAM_CW_W-1:0] cw,
  output ham_dec_t            dec
);

  logic [HAM_SYN_W-1:0] synd;
  logic [HAM_CW_W-1:0]  flip;
  logic [HAM_CW_W-1:0]  fixed;

  assign synd[0] = ^(cw & HAM_SYN_MASK0);
  assign synd[1] = ^(cw & HAM_SYN_MASK1);
  assign synd[2] = ^(cw & HAM_SYN_MASK2);
  assign synd[3] = ^(cw & HAM_SYN_MASK3);

  // A non-zero syndrome is the 1-based position of the bit to flip.
  assign flip  = (synd != '0) ? (HAM_CW_W'(1) << (synd - 4'd1)) : '0;
  assign fixed = cw ^ flip;

  assign dec.data = ham_extract(fixed);
  assign dec.synd = synd;
  assign dec.corr = (synd != '0);

endmodule

// File: rtl/hamming_dec_arbiter.sv
// Round-robin arbiter sharing one Hamming(15,11) corrector among NUM_REQ requesters.
// Optional per-requester corrected-word counters are built when HAM_ERR_CNT_EN is defined.
module hamming_dec_arbiter
  import hamming_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [HAM_CW_W*NUM_REQ-1:0]  req_code,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [HAM_DATA_W-1:0]        out_data,
  output logic [ID_W-1:0]              out_id,
  output logic [HAM_SYN_W-1:0]         out_synd,
  output logic                         out_corr,
  output logic [CNT_W*NUM_REQ-1:0]     err_cnt
);

  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_found;
  logic [ID_W:0]       cand;
  logic                slot_free;
  logic                accept;
  logic [ID_W-1:0]     ptr_next;
  logic [HAM_CW_W-1:0] gnt_code;
  ham_dec_t            dec;

  // Readiness is gated by reset so nothing is accepted while the block is being cleared.
  assign slot_free = (!out_valid || out_ready) && !rst;
  assign accept    = slot_free && gnt_found;

  // NOTE: combinational blocks assign every output a default first and use blocking
  // assignments, so no latch is inferred and later loop iterations see earlier results.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    // Scan from the farthest candidate back to the pointer so the nearest valid one wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (req_valid[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    gnt_code  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        req_ready[i] = accept;
        gnt_code     = req_code[i*HAM_CW_W +: HAM_CW_W];
      end
    end
  end

  assign ptr_next = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

  hamming15_11_correct u_correct (
    .cw  (gnt_code),
    .dec (dec)
  );

  // NOTE: sequential state uses non-blocking assignments only; reset here is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_synd  <= '0;
      out_corr  <= 1'b0;
      ptr       <= '0;
    end else if (slot_free) begin
      out_valid <= accept;
      if (accept) begin
        out_data <= dec.data;
        out_id   <= gnt_idx;
        out_synd <= dec.synd;
        out_corr <= dec.corr;
        ptr      <= ptr_next;
      end
    end
  end

`ifdef HAM_ERR_CNT_EN
  logic [CNT_W-1:0] cnt [NUM_REQ];

  // NOTE: the counter array is a handful of flops, not a RAM, so it takes a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && gnt_idx == ID_W'(i) && dec.corr && cnt[i] != '1)
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    err_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) err_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_hamming_dec_arbiter.sv
// Randomized self-checking bench for hamming_dec_arbiter against a behavioural model.
module tb_hamming_dec_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;
  localparam int CNT_W   = 16;
  localparam int CW      = 15;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_REQ-1:0]      req_valid = '1;
  logic [NUM_REQ-1:0]      req_ready;
  logic [CW*NUM_REQ-1:0]   req_code = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [10:0]             out_data;
  logic [ID_W-1:0]         out_id;
  logic [3:0]              out_synd;
  logic                    out_corr;
  logic [CNT_W*NUM_REQ-1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: what the output register should hold after the latest edge.
  logic        m_valid = 1'b0;
  logic [10:0] m_data  = '0;
  int          m_id    = 0;
  logic [3:0]  m_synd  = '0;
  logic        m_corr  = 1'b0;
  int          m_ptr   = 0;
  int          m_cnt [NUM_REQ];

  hamming_dec_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_code  (req_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_synd  (out_synd),
    .out_corr  (out_corr),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Syndrome = XOR of the 1-based positions of all set bits; data = non-power-of-two positions.
  task automatic ref_decode(input logic [14:0] cw_in, output logic [10:0] d, output logic [3:0] s);
    logic [14:0] cw;
    int syn;
    int k;
    cw  = cw_in;
    syn = 0;
    for (int i = 0; i < CW; i++) if (cw[i]) syn = syn ^ (i + 1);
    if (syn != 0) cw[syn-1] = ~cw[syn-1];
    d = '0;
    k = 0;
    for (int i = 0; i < CW; i++) begin
      int p;
      p = i + 1;
      if ((p & (p - 1)) != 0) begin
        d[k] = cw[i];
        k++;
      end
    end
    s = 4'(syn);
  endtask

  task automatic check_outputs();
    logic [CNT_W*NUM_REQ-1:0] exp_cnt;
    exp_cnt = '0;
`ifdef HAM_ERR_CNT_EN
    for (int i = 0; i < NUM_REQ; i++) exp_cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
`endif
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_data",  64'(out_data),  64'(m_data));
    check("out_id",    64'(out_id),    64'(m_id));
    check("out_synd",  64'(out_synd),  64'(m_synd));
    check("out_corr",  64'(out_corr),  64'(m_corr));
    check("err_cnt",   64'(err_cnt),   64'(exp_cnt));
  endtask

  // One clock: check registered outputs, apply inputs, check ready, advance the model.
  task automatic step(input logic r, input logic [NUM_REQ-1:0] v,
                      input logic [CW*NUM_REQ-1:0] c, input logic o);
    int g;
    logic [NUM_REQ-1:0] exp_ready;
    logic [10:0] d;
    logic [3:0] s;
    @(negedge clk);
    check_outputs();
    rst = r; req_valid = v; req_code = c; out_ready = o;
    #1;
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (g < 0 && v[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
    end
    exp_ready = '0;
    if (!r && (!m_valid || o) && g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0; m_data = '0; m_id = 0; m_synd = '0; m_corr = 1'b0; m_ptr = 0;
      for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
    end else if (!m_valid || o) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        ref_decode(c[g*CW +: CW], d, s);
        m_data = d; m_synd = s; m_corr = (s != 0); m_id = g;
        m_ptr = (g + 1) % NUM_REQ;
        if (s != 0 && m_cnt[g] < (1 << CNT_W) - 1) m_cnt[g]++;
      end
    end
  endtask

  function automatic logic [CW*NUM_REQ-1:0] rand_codes();
    logic [CW*NUM_REQ-1:0] c;
    for (int i = 0; i < NUM_REQ; i++) c[i*CW +: CW] = CW'($urandom);
    return c;
  endfunction

  initial begin
    for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;

    // Reset held with every input active.
    step(1'b1, '1, rand_codes(), 1'b1);
    step(1'b1, '1, rand_codes(), 1'b1);

    // Clean all-ones word from requester 0, then a single-bit error from requester 1.
    step(1'b0, 2'b01, {15'h0000, 15'h7FFF}, 1'b1);
    step(1'b0, 2'b10, {15'h0020, 15'h0000}, 1'b1);
    step(1'b0, 2'b00, '0, 1'b1);
    check("corr_synd_direct", 64'(out_synd), 64'd6);

    // Both requesters continuously valid: grants must alternate.
    for (int n = 0; n < 6; n++) step(1'b0, 2'b11, rand_codes(), 1'b1);

    // Stall for three cycles with a word held, then release.
    for (int n = 0; n < 3; n++) step(1'b0, 2'b11, rand_codes(), 1'b0);
    for (int n = 0; n < 3; n++) step(1'b0, 2'b11, rand_codes(), 1'b1);

    // Reset while stalled drops the held word.
    step(1'b0, 2'b11, rand_codes(), 1'b0);
    step(1'b1, 2'b11, rand_codes(), 1'b0);
    step(1'b0, 2'b00, '0, 1'b1);

    // Randomized traffic with occasional back-pressure and resets.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 79) == 0),
           NUM_REQ'($urandom),
           rand_codes(),
           ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    check_outputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
